// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//   Multi-channel fractional clock-enable generator on a single reference
//   clock. Each channel runs a phase accumulator. The registered carry out of
//   the accumulator is a one-cycle clock-enable pulse at f_ref*inc/2^ACC_W.
//   A two-state lock FSM holds every channel at phase zero until the
//   configuration has been stable for LOCK_CYCLES cycles. It then releases
//   all channels together, so channels with equal increments pulse in step.
//
// Ports
//   refclk   in   1              reference clock, rising-edge logic
//   rst      in   1              asynchronous active-high reset
//                                (release must be synchronised externally)
//   inc      in   NUM_CH*ACC_W   per-channel increment, ch n = inc[n*ACC_W +: ACC_W]
//   ce       out  NUM_CH         per-channel enable pulse, one refclk wide
//   clk_div  out  NUM_CH         per-channel square wave, toggles on each ce
//   locked   out  1              configuration settled and channels running
// -----------------------------------------------------------------------------
module clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_div,
  output logic                    locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lock_cnt;
  logic [ACC_W-1:0] acc   [NUM_CH];
  logic [ACC_W-1:0] inc_q [NUM_CH];
  logic [ACC_W:0]   sum   [NUM_CH];  // MSB is the accumulator carry
  logic             change;
  logic             lock_done;

  // A difference between the live and the captured increment on any channel
  // means the configuration is still moving.
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path
    // leaves it unassigned, which would infer a latch.
    change = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      sum[n] = {1'b0, acc[n]} + {1'b0, inc_q[n]};
      if (inc[n*ACC_W +: ACC_W] != inc_q[n]) change = 1'b1;
    end
  end

  assign lock_done = (lock_cnt == CNT_W'(LOCK_CYCLES - 1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      // NOTE: acc/inc_q are small per-channel register arrays, not RAM.
      // Resetting them costs nothing and gives a defined start phase.
      for (int n = 0; n < NUM_CH; n++) begin
        acc[n]   <= '0;
        inc_q[n] <= '0;
      end
      state    <= SETTLE;
      lock_cnt <= '0;
      ce       <= '0;
      clk_div  <= '0;
      locked   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values. change compares inc against the old inc_q.
      for (int n = 0; n < NUM_CH; n++) begin
        inc_q[n] <= inc[n*ACC_W +: ACC_W];
      end

      case (state)
        SETTLE: begin
          ce <= '0;
          for (int n = 0; n < NUM_CH; n++) acc[n] <= '0;
          // A change has priority over lock completion on the same edge.
          if (change) begin
            lock_cnt <= '0;
          end else if (lock_done) begin
            state  <= RUN;
            locked <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (change) begin
            state    <= SETTLE;
            locked   <= 1'b0;
            lock_cnt <= '0;
            ce       <= '0;
            for (int n = 0; n < NUM_CH; n++) acc[n] <= '0;
          end else begin
            // ce and clk_div are registered on the wrap edge itself, so
            // clk_div changes in the same cycle that ce is seen high.
            for (int n = 0; n < NUM_CH; n++) begin
              acc[n] <= sum[n][ACC_W-1:0];
              ce[n]  <= sum[n][ACC_W];
              if (sum[n][ACC_W]) clk_div[n] <= ~clk_div[n];
            end
          end
        end

        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
//   Directed bench for clk_enable_gen with ACC_W=8, NUM_CH=2, LOCK_CYCLES=16.
//   Edge numbers count rising edges after reset release, starting from 0.
//   Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 16;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       clk_div;
  logic                    locked;

  clk_enable_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .inc     (inc),
    .ce      (ce),
    .clk_div (clk_div),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int         edge_no;
    logic [1:0] ce;
    logic [1:0] div;
    logic       lk;
  } vec_t;

  vec_t vecs [13];

  int total = 0;
  int bad   = 0;
  int edge_cnt;
  int p0, p1;
  logic lk_seen, ce_seen;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance one rising edge, sample just after it, and accumulate statistics.
  task automatic tick();
    @(posedge refclk);
    #1;
    edge_cnt++;
    p0 += int'(ce[0]);
    p1 += int'(ce[1]);
    if (locked)   lk_seen = 1'b1;
    if (ce != '0) ce_seen = 1'b1;
  endtask

  initial begin
    // Lock-up sequence with inc = {ch1=128, ch0=64}. Lock happens at edge 16.
    // ch0 wraps at edges 20,24,28 and ch1 at edges 18,20,22,...
    vecs[0]  = '{0,  2'b00, 2'b00, 1'b0};
    vecs[1]  = '{15, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{16, 2'b00, 2'b00, 1'b1};
    vecs[3]  = '{17, 2'b00, 2'b00, 1'b1};
    vecs[4]  = '{18, 2'b10, 2'b10, 1'b1};
    vecs[5]  = '{19, 2'b00, 2'b10, 1'b1};
    vecs[6]  = '{20, 2'b11, 2'b01, 1'b1};
    vecs[7]  = '{21, 2'b00, 2'b01, 1'b1};
    vecs[8]  = '{22, 2'b10, 2'b11, 1'b1};
    vecs[9]  = '{23, 2'b00, 2'b11, 1'b1};
    vecs[10] = '{24, 2'b11, 2'b00, 1'b1};
    vecs[11] = '{26, 2'b10, 2'b10, 1'b1};
    vecs[12] = '{28, 2'b11, 2'b01, 1'b1};

    p0 = 0; p1 = 0; lk_seen = 1'b0; ce_seen = 1'b0;
    edge_cnt = -1;
    rst = 1'b1;
    inc = {8'd128, 8'd64};
    #1;
    check("reset_ce",      32'(ce),      32'd0);
    check("reset_clk_div", 32'(clk_div), 32'd0);
    check("reset_locked",  32'(locked),  32'd0);

    repeat (3) @(posedge refclk);
    #1 rst = 1'b0;

    // Table-driven lock and pulse pattern.
    for (int i = 0; i < 13; i++) begin
      while (edge_cnt < vecs[i].edge_no) tick();
      check($sformatf("vec%0d_ce", vecs[i].edge_no),     32'(ce),      32'(vecs[i].ce));
      check($sformatf("vec%0d_div", vecs[i].edge_no),    32'(clk_div), 32'(vecs[i].div));
      check($sformatf("vec%0d_locked", vecs[i].edge_no), 32'(locked),  32'(vecs[i].lk));
    end

    // Rate change while locked: drop lock on the next edge, relock 16 edges later.
    inc[7:0] = 8'd32;
    tick();
    check("chg_locked_drop", 32'(locked), 32'd0);
    check("chg_ce_clear",    32'(ce),     32'd0);
    repeat (15) tick();
    check("chg_locked_15", 32'(locked), 32'd0);
    tick();
    check("chg_locked_16", 32'(locked), 32'd1);
    p0 = 0;
    repeat (7) tick();
    check("chg_ch0_quiet", 32'(p0),    32'd0);
    tick();
    check("chg_ch0_first", 32'(ce[0]), 32'd1);
    p0 = 0;
    repeat (56) tick();
    check("chg_ch0_rate", 32'(p0), 32'd7);

    // Configuration changing every 10 cycles never settles.
    lk_seen = 1'b0; ce_seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      inc[7:0] = 8'(40 + r);
      repeat (10) tick();
    end
    check("churn_never_locked", 32'(lk_seen), 32'd0);
    check("churn_no_ce",        32'(ce_seen), 32'd0);

    // Extreme increments: 0 never pulses, 255 misses one edge per 256.
    inc = {8'd255, 8'd0};
    repeat (17) tick();
    check("ext_locked", 32'(locked), 32'd1);
    for (int w = 0; w < 4; w++) begin
      p0 = 0; p1 = 0;
      repeat (256) tick();
      check($sformatf("ext_ch0_win%0d", w), 32'(p0), 32'd0);
      check($sformatf("ext_ch1_win%0d", w), 32'(p1), 32'd255);
    end

    // Short reset pulse between clock edges clears everything at once.
    #2 rst = 1'b1;
    #1;
    check("rstpulse_ce",      32'(ce),      32'd0);
    check("rstpulse_clk_div", 32'(clk_div), 32'd0);
    check("rstpulse_locked",  32'(locked),  32'd0);
    #1 rst = 1'b0;
    edge_cnt = -1;
    repeat (16) tick();
    check("relock_15", 32'(locked), 32'd0);
    tick();
    check("relock_16", 32'(locked), 32'd1);
    tick();
    check("relock_ce_17", 32'(ce), 32'd0);
    tick();
    check("relock_ce_18",  32'(ce),      32'd2);
    check("relock_div_18", 32'(clk_div), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
